// File: rtl/inst_queue_dual.sv
// inst_queue_dual: circular instruction FIFO between fetch (IF) and decode (Dec).
//
// Fetch offers up to two instructions per cycle. Lane 0 is the older one. Each
// instruction carries its PC and a BTB prediction. Decode sees one registered
// entry per cycle and consumes it with Dec_flag.
//
// Ports:
//   clk, rst              clock; synchronous active-high reset
//   rdy                   global enable; when low, all state holds
//   roll                  flush on branch misprediction (data outputs hold)
//   IF_cnt                number of lanes offered (0..2; 3 is treated as 0)
//   IF_inst*/IF_PC*/IF_BTB_PC*/IF_BTB_predict*   lane 0 / lane 1 payload
//   Dec_flag              decoder consumed the presented entry
//   Dec_commit            output register holds a valid entry
//   Dec_inst/PC/BTB_PC/BTB_predict   presented entry
//   IQ_full               registered; fetch must not push while high
//   IQ_count              registered occupancy (includes the presented entry)
//
// Optional feature: define IQ_BYPASS_EN to let lane 0 go straight to the
// output register when the queue would otherwise present nothing. This cuts
// fetch-to-decode latency from 2 to 1 cycle.
module inst_queue_dual #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned XLEN  = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    rdy,
  input  logic                    roll,
  input  logic [1:0]              IF_cnt,
  input  logic [XLEN-1:0]         IF_inst0,
  input  logic [XLEN-1:0]         IF_inst1,
  input  logic [XLEN-1:0]         IF_PC0,
  input  logic [XLEN-1:0]         IF_PC1,
  input  logic [XLEN-1:0]         IF_BTB_PC0,
  input  logic [XLEN-1:0]         IF_BTB_PC1,
  input  logic                    IF_BTB_predict0,
  input  logic                    IF_BTB_predict1,
  input  logic                    Dec_flag,
  output logic                    Dec_commit,
  output logic [XLEN-1:0]         Dec_inst,
  output logic [XLEN-1:0]         Dec_PC,
  output logic [XLEN-1:0]         Dec_BTB_PC,
  output logic                    Dec_BTB_predict,
  output logic                    IQ_full,
  output logic [$clog2(DEPTH):0]  IQ_count
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  logic [XLEN-1:0] inst_mem_q [DEPTH];
  logic [XLEN-1:0] pc_mem_q   [DEPTH];
  logic [XLEN-1:0] btb_mem_q  [DEPTH];
  logic            pred_mem_q [DEPTH];

  logic [PW-1:0]   head_q, head_d, tail_q, tail_d, wr1_idx;
  logic [CW-1:0]   count_q, count_d;
  logic            full_q, full_d;
  logic            commit_q, commit_d;
  logic [XLEN-1:0] inst_q, inst_d, pc_q, pc_d, btb_q, btb_d;
  logic            pred_q, pred_d;

  logic [1:0]      enq;
  logic            deq;
  logic            wr_en;

  // Effective handshake and pointer/occupancy next state
  always_comb begin
    enq     = (full_q || (IF_cnt == 2'd3)) ? 2'd0 : IF_cnt;
    deq     = Dec_flag & commit_q;
    head_d  = head_q + PW'(deq);
    tail_d  = tail_q + PW'(enq);
    wr1_idx = tail_q + PW'(1);
    count_d = count_q + CW'(enq) - CW'(deq);
    // Full once fewer than two free slots remain, so a dual push always fits
    full_d  = (count_d > CW'(DEPTH - 2));
  end

  // Output register next state, decided on the pre-edge occupancy.
  // head_d is the index of the entry that follows the one being consumed.
  always_comb begin
    commit_d = 1'b0;
    inst_d   = inst_q;
    pc_d     = pc_q;
    btb_d    = btb_q;
    pred_d   = pred_q;
    if (count_q > CW'(deq)) begin
      commit_d = 1'b1;
      inst_d   = inst_mem_q[head_d];
      pc_d     = pc_mem_q[head_d];
      btb_d    = btb_mem_q[head_d];
      pred_d   = pred_mem_q[head_d];
    end
`ifdef IQ_BYPASS_EN
    else if (enq != 2'd0) begin
      // Queue drains this cycle: present lane 0 directly. It is still
      // written to storage below and becomes the new head.
      commit_d = 1'b1;
      inst_d   = IF_inst0;
      pc_d     = IF_PC0;
      btb_d    = IF_BTB_PC0;
      pred_d   = IF_BTB_predict0;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head_q   <= '0;
      tail_q   <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      commit_q <= 1'b0;
      inst_q   <= '0;
      pc_q     <= '0;
      btb_q    <= '0;
      pred_q   <= 1'b0;
    end else if (roll) begin
      // Flush control state only; the stale payload stays on the outputs
      head_q   <= '0;
      tail_q   <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      commit_q <= 1'b0;
    end else if (rdy) begin
      head_q   <= head_d;
      tail_q   <= tail_d;
      count_q  <= count_d;
      full_q   <= full_d;
      commit_q <= commit_d;
      inst_q   <= inst_d;
      pc_q     <= pc_d;
      btb_q    <= btb_d;
      pred_q   <= pred_d;
    end
  end

  assign wr_en = !rst && !roll && rdy;

  // Storage is not reset: entries beyond count are never presented
  always_ff @(posedge clk) begin
    if (wr_en) begin
      if (enq != 2'd0) begin
        inst_mem_q[tail_q] <= IF_inst0;
        pc_mem_q[tail_q]   <= IF_PC0;
        btb_mem_q[tail_q]  <= IF_BTB_PC0;
        pred_mem_q[tail_q] <= IF_BTB_predict0;
      end
      if (enq == 2'd2) begin
        inst_mem_q[wr1_idx] <= IF_inst1;
        pc_mem_q[wr1_idx]   <= IF_PC1;
        btb_mem_q[wr1_idx]  <= IF_BTB_PC1;
        pred_mem_q[wr1_idx] <= IF_BTB_predict1;
      end
    end
  end

  assign Dec_commit      = commit_q;
  assign Dec_inst        = inst_q;
  assign Dec_PC          = pc_q;
  assign Dec_BTB_PC      = btb_q;
  assign Dec_BTB_predict = pred_q;
  assign IQ_full         = full_q;
  assign IQ_count        = count_q;

endmodule

// File: tb/tb_inst_queue_dual.sv
// Self-checking bench for inst_queue_dual (DEPTH = 16, XLEN = 32).
// Pushed entries go into a scoreboard queue and are compared when the decoder
// consumes them. Each test also checks occupancy, full and commit inline.
module tb_inst_queue_dual;
  localparam int unsigned DEPTH = 16;
  localparam int unsigned XLEN  = 32;

  logic                   clk = 1'b0;
  logic                   rst, rdy, roll, Dec_flag;
  logic [1:0]             IF_cnt;
  logic [XLEN-1:0]        IF_inst0, IF_inst1, IF_PC0, IF_PC1, IF_BTB_PC0, IF_BTB_PC1;
  logic                   IF_BTB_predict0, IF_BTB_predict1;
  logic                   Dec_commit, Dec_BTB_predict, IQ_full;
  logic [XLEN-1:0]        Dec_inst, Dec_PC, Dec_BTB_PC;
  logic [$clog2(DEPTH):0] IQ_count;

  int nchecks = 0;
  int nerrors = 0;

  // Reference model state
  logic [31:0] sb [$];
  int          m_count  = 0;
  logic        m_commit = 1'b0;
  logic [31:0] m_pc     = '0;

  always #5 clk = ~clk;

  inst_queue_dual #(.DEPTH(DEPTH), .XLEN(XLEN)) dut (
    .clk(clk), .rst(rst), .rdy(rdy), .roll(roll), .IF_cnt(IF_cnt),
    .IF_inst0(IF_inst0), .IF_inst1(IF_inst1), .IF_PC0(IF_PC0), .IF_PC1(IF_PC1),
    .IF_BTB_PC0(IF_BTB_PC0), .IF_BTB_PC1(IF_BTB_PC1),
    .IF_BTB_predict0(IF_BTB_predict0), .IF_BTB_predict1(IF_BTB_predict1),
    .Dec_flag(Dec_flag), .Dec_commit(Dec_commit), .Dec_inst(Dec_inst), .Dec_PC(Dec_PC),
    .Dec_BTB_PC(Dec_BTB_PC), .Dec_BTB_predict(Dec_BTB_predict),
    .IQ_full(IQ_full), .IQ_count(IQ_count)
  );

  // Payload fields derived from the PC so one value identifies an entry
  function automatic logic [31:0] f_inst(input logic [31:0] pc);
    return pc ^ 32'hA5A5_0000;
  endfunction
  function automatic logic [31:0] f_btb(input logic [31:0] pc);
    return pc + 32'h40;
  endfunction
  function automatic logic f_pred(input logic [31:0] pc);
    return pc[3];
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_model();
    sb.delete();
    m_count  = 0;
    m_commit = 1'b0;
    m_pc     = '0;
  endtask

  // One clock: drive inputs, update the scoreboard, pop/compare on consume
  task automatic step(input int cnt, input logic [31:0] pc0, input logic flag,
                      input logic rl, input logic en);
    int          enq;
    int          prev;
    logic        deq;
    logic [31:0] exp_pc;
    IF_cnt          = 2'(cnt);
    IF_PC0          = pc0;
    IF_PC1          = pc0 + 32'd4;
    IF_inst0        = f_inst(pc0);
    IF_inst1        = f_inst(pc0 + 32'd4);
    IF_BTB_PC0      = f_btb(pc0);
    IF_BTB_PC1      = f_btb(pc0 + 32'd4);
    IF_BTB_predict0 = f_pred(pc0);
    IF_BTB_predict1 = f_pred(pc0 + 32'd4);
    Dec_flag        = flag;
    roll            = rl;
    rdy             = en;
    if (rl) begin
      sb.delete();
      m_count  = 0;
      m_commit = 1'b0;
    end else if (en) begin
      enq = (m_count > int'(DEPTH) - 2 || cnt == 3) ? 0 : cnt;
      deq = flag && m_commit;
      if (deq) begin
        exp_pc = sb.pop_front();
        nchecks++;
        if (Dec_PC !== exp_pc || Dec_inst !== f_inst(exp_pc) ||
            Dec_BTB_PC !== f_btb(exp_pc) || Dec_BTB_predict !== f_pred(exp_pc)) begin
          nerrors++;
          $display("FAIL sb_pop: got PC=%h inst=%h btb=%h pred=%b, need PC=%h inst=%h btb=%h pred=%b",
                   Dec_PC, Dec_inst, Dec_BTB_PC, Dec_BTB_predict,
                   exp_pc, f_inst(exp_pc), f_btb(exp_pc), f_pred(exp_pc));
        end
      end
      prev = m_count;
      if (enq >= 1) sb.push_back(pc0);
      if (enq == 2) sb.push_back(pc0 + 32'd4);
      m_count = prev + enq - int'(deq);
`ifdef IQ_BYPASS_EN
      m_commit = (prev > int'(deq)) || (enq > 0);
`else
      m_commit = prev > int'(deq);
`endif
      if (m_commit) m_pc = sb[0];
    end
    tick();
  endtask

  task automatic test_reset(input logic with_traffic);
    if (with_traffic) begin
      step(2, 32'h9000, 1'b0, 1'b0, 1'b1);
      step(0, 32'h0, 1'b0, 1'b0, 1'b1);
    end
    // Reset wins over a stalled rdy and offered traffic
    rst = 1'b1; rdy = 1'b0; roll = 1'b0; IF_cnt = 2'd2; Dec_flag = 1'b1;
    tick();
    rst = 1'b0; rdy = 1'b1; IF_cnt = 2'd0; Dec_flag = 1'b0;
    clear_model();
    nchecks++; if (Dec_commit !== 1'b0) begin nerrors++; $display("FAIL rst_commit: got %b need 0", Dec_commit); end
    nchecks++; if (IQ_count !== '0) begin nerrors++; $display("FAIL rst_count: got %0d need 0", IQ_count); end
    nchecks++; if (IQ_full !== 1'b0) begin nerrors++; $display("FAIL rst_full: got %b need 0", IQ_full); end
    nchecks++;
    if (Dec_inst !== '0 || Dec_PC !== '0 || Dec_BTB_PC !== '0 || Dec_BTB_predict !== 1'b0) begin
      nerrors++;
      $display("FAIL rst_data: got inst=%h PC=%h btb=%h pred=%b need all 0",
               Dec_inst, Dec_PC, Dec_BTB_PC, Dec_BTB_predict);
    end
  endtask

  task automatic test_dual_push();
    step(2, 32'h100, 1'b0, 1'b0, 1'b1);
`ifdef IQ_BYPASS_EN
    nchecks++; if (Dec_commit !== 1'b1 || Dec_PC !== 32'h100) begin nerrors++; $display("FAIL dual_bypass: got commit=%b PC=%h need 1/100", Dec_commit, Dec_PC); end
`else
    nchecks++; if (Dec_commit !== 1'b0) begin nerrors++; $display("FAIL dual_lat1: got commit=%b need 0", Dec_commit); end
`endif
    nchecks++; if (IQ_count !== 5'd2) begin nerrors++; $display("FAIL dual_count: got %0d need 2", IQ_count); end
    step(0, 32'h0, 1'b0, 1'b0, 1'b1);
    nchecks++; if (Dec_commit !== 1'b1 || Dec_PC !== 32'h100) begin nerrors++; $display("FAIL dual_lat2: got commit=%b PC=%h need 1/100", Dec_commit, Dec_PC); end
    step(0, 32'h0, 1'b1, 1'b0, 1'b1);
    nchecks++; if (Dec_commit !== 1'b1 || Dec_PC !== 32'h104) begin nerrors++; $display("FAIL dual_second: got commit=%b PC=%h need 1/104", Dec_commit, Dec_PC); end
    nchecks++; if (IQ_count !== 5'd1) begin nerrors++; $display("FAIL dual_count1: got %0d need 1", IQ_count); end
    step(0, 32'h0, 1'b1, 1'b0, 1'b1);
    nchecks++; if (Dec_commit !== 1'b0 || IQ_count !== '0) begin nerrors++; $display("FAIL dual_empty: got commit=%b count=%0d need 0/0", Dec_commit, IQ_count); end
  endtask

  task automatic test_fill();
    for (int i = 0; i < 8; i++) begin
      step(2, 32'h1000 + 32'(8 * i), 1'b0, 1'b0, 1'b1);
      if (i == 6) begin
        // 14 held: exactly two slots free, so not yet full
        nchecks++; if (IQ_count !== 5'd14 || IQ_full !== 1'b0) begin nerrors++; $display("FAIL fill_14: got count=%0d full=%b need 14/0", IQ_count, IQ_full); end
      end
    end
    nchecks++; if (IQ_count !== 5'd16 || IQ_full !== 1'b1) begin nerrors++; $display("FAIL fill_16: got count=%0d full=%b need 16/1", IQ_count, IQ_full); end
    step(2, 32'h1F00, 1'b0, 1'b0, 1'b1);
    nchecks++; if (IQ_count !== 5'd16 || IQ_full !== 1'b1) begin nerrors++; $display("FAIL overflow_guard: got count=%0d full=%b need 16/1", IQ_count, IQ_full); end
    // Back-to-back drain; a push offered while full is dropped
    for (int i = 0; i < 16; i++) begin
      step((i == 0) ? 2 : 0, 32'h1F80, 1'b1, 1'b0, 1'b1);
      nchecks++; if (IQ_count !== 5'(15 - i)) begin nerrors++; $display("FAIL drain_count[%0d]: got %0d need %0d", i, IQ_count, 15 - i); end
      nchecks++; if (Dec_commit !== (i < 15)) begin nerrors++; $display("FAIL drain_commit[%0d]: got %b need %b", i, Dec_commit, i < 15); end
      nchecks++; if (IQ_full !== ((15 - i) > 14)) begin nerrors++; $display("FAIL drain_full[%0d]: got %b", i, IQ_full); end
    end
  endtask

  task automatic test_wrap();
    logic [31:0] next_pc = 32'h8000_0000;
    int          c;
    // Offset tail to odd so a lane-1 write lands on the last index
    step(1, next_pc, 1'b1, 1'b0, 1'b1);
    next_pc += 32'd4;
    for (int i = 0; i < 20; i++) begin
      c = (i % 2 == 0) ? 2 : 1;
      step(c, next_pc, 1'b1, 1'b0, 1'b1);
      next_pc += 32'(4 * c);
      nchecks++; if (IQ_count !== 5'(m_count)) begin nerrors++; $display("FAIL wrap_count[%0d]: got %0d need %0d", i, IQ_count, m_count); end
      nchecks++; if (Dec_commit !== m_commit || (m_commit && Dec_PC !== m_pc)) begin nerrors++; $display("FAIL wrap_out[%0d]: got commit=%b PC=%h need %b/%h", i, Dec_commit, Dec_PC, m_commit, m_pc); end
    end
    for (int k = 0; k < 40 && m_count > 0; k++) step(0, 32'h0, 1'b1, 1'b0, 1'b1);
    nchecks++; if (IQ_count !== '0 || sb.size() != 0) begin nerrors++; $display("FAIL wrap_drain: got count=%0d left=%0d need 0/0", IQ_count, sb.size()); end
  endtask

  task automatic test_roll();
    step(2, 32'h2000, 1'b0, 1'b0, 1'b1);
    step(2, 32'h2008, 1'b0, 1'b0, 1'b1);
    step(1, 32'h2010, 1'b0, 1'b0, 1'b1);
    step(0, 32'h0, 1'b0, 1'b0, 1'b1);
    nchecks++; if (IQ_count !== 5'd5 || Dec_PC !== 32'h2000) begin nerrors++; $display("FAIL roll_pre: got count=%0d PC=%h need 5/2000", IQ_count, Dec_PC); end
    step(2, 32'h3000, 1'b1, 1'b1, 1'b1);
    nchecks++; if (IQ_count !== '0 || Dec_commit !== 1'b0 || IQ_full !== 1'b0) begin nerrors++; $display("FAIL roll_flush: got count=%0d commit=%b full=%b need 0/0/0", IQ_count, Dec_commit, IQ_full); end
    nchecks++; if (Dec_PC !== 32'h2000) begin nerrors++; $display("FAIL roll_hold: got PC=%h need 2000", Dec_PC); end
    step(1, 32'h4000, 1'b0, 1'b0, 1'b1);
    step(0, 32'h0, 1'b0, 1'b0, 1'b1);
    nchecks++; if (Dec_commit !== 1'b1 || Dec_PC !== 32'h4000 || IQ_count !== 5'd1) begin nerrors++; $display("FAIL roll_restart: got commit=%b PC=%h count=%0d need 1/4000/1", Dec_commit, Dec_PC, IQ_count); end
    step(0, 32'h0, 1'b1, 1'b0, 1'b1);
    nchecks++; if (IQ_count !== '0 || Dec_commit !== 1'b0) begin nerrors++; $display("FAIL roll_drain: got count=%0d commit=%b need 0/0", IQ_count, Dec_commit); end
  endtask

  task automatic test_stall();
    step(2, 32'h5000, 1'b0, 1'b0, 1'b1);
    step(2, 32'h5008, 1'b0, 1'b0, 1'b1);
    step(0, 32'h0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      step(2, 32'h6000, 1'b1, 1'b0, 1'b0);
      nchecks++;
      if (IQ_count !== 5'd4 || Dec_commit !== 1'b1 || Dec_PC !== 32'h5000 || IQ_full !== 1'b0) begin
        nerrors++;
        $display("FAIL stall_hold[%0d]: got count=%0d commit=%b PC=%h full=%b need 4/1/5000/0",
                 i, IQ_count, Dec_commit, Dec_PC, IQ_full);
      end
    end
    // Resume: consume immediately; IF_cnt = 3 must not enqueue
    step(3, 32'h7000, 1'b1, 1'b0, 1'b1);
    nchecks++; if (IQ_count !== 5'd3 || Dec_PC !== 32'h5004) begin nerrors++; $display("FAIL stall_resume: got count=%0d PC=%h need 3/5004", IQ_count, Dec_PC); end
    for (int k = 0; k < 10 && m_count > 0; k++) step(0, 32'h0, 1'b1, 1'b0, 1'b1);
    nchecks++; if (IQ_count !== '0 || sb.size() != 0) begin nerrors++; $display("FAIL stall_drain: got count=%0d left=%0d need 0/0", IQ_count, sb.size()); end
  endtask

  initial begin
    rst = 1'b0; rdy = 1'b1; roll = 1'b0; Dec_flag = 1'b0; IF_cnt = 2'd0;
    IF_inst0 = '0; IF_inst1 = '0; IF_PC0 = '0; IF_PC1 = '0;
    IF_BTB_PC0 = '0; IF_BTB_PC1 = '0; IF_BTB_predict0 = 1'b0; IF_BTB_predict1 = 1'b0;
    test_reset(1'b0);
    test_dual_push();
    test_fill();
    test_wrap();
    test_roll();
    test_stall();
    test_reset(1'b1);
    $display("Result: errors=%0d of %0d checks", nerrors, nchecks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
